// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control slice: opcodes, FSM states, default widths.
`timescale 1ns/1ps
package alu_ctrl_pkg;

   localparam int DBITS  = 32;
   localparam int OPBITS = 6;

   localparam logic [OPBITS-1:0] OP_ADD  = 6'd0;
   localparam logic [OPBITS-1:0] OP_SUB  = 6'd1;
   localparam logic [OPBITS-1:0] OP_AND  = 6'd2;
   localparam logic [OPBITS-1:0] OP_OR   = 6'd3;
   localparam logic [OPBITS-1:0] OP_XOR  = 6'd4;
   localparam logic [OPBITS-1:0] OP_NAND = 6'd5;
   localparam logic [OPBITS-1:0] OP_NOR  = 6'd6;
   localparam logic [OPBITS-1:0] OP_XNOR = 6'd7;
   localparam logic [OPBITS-1:0] OP_MVHI = 6'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the caller keeps last_grant (index of the previous winner).
`timescale 1ns/1ps
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   // A lone requester wins outright; on a tie the one that did not win last time goes.
   always_comb begin
      // NOTE: default first so every path assigns gnt and no latch is inferred.
      gnt = req;
      if (req == 2'b11) begin
         gnt = last_grant ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters: arbitrate, drive the ALU,
// wait ALU_LAT edges, capture the result and hand it back on the winner's response channel.
`timescale 1ns/1ps
module alu_arbiter #(
   parameter int DBITS   = alu_ctrl_pkg::DBITS,
   parameter int OPBITS  = alu_ctrl_pkg::OPBITS,
   parameter int ALU_LAT = 1                      // must be >= 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OPBITS-1:0] req0_op,
   input  logic [DBITS-1:0]  req0_a,
   input  logic [DBITS-1:0]  req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OPBITS-1:0] req1_op,
   input  logic [DBITS-1:0]  req1_a,
   input  logic [DBITS-1:0]  req1_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DBITS-1:0]  rsp0_data,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DBITS-1:0]  rsp1_data,
   output logic [OPBITS-1:0] alu_opsel,
   output logic [DBITS-1:0]  alu_a,
   output logic [DBITS-1:0]  alu_b,
   input  logic [DBITS-1:0]  alu_out,
   output logic              busy
);
   import alu_ctrl_pkg::*;

   localparam int CBITS = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_t             state, state_nx;
   logic [CBITS-1:0]   cnt;
   logic               last_grant;
   logic               who;          // index of the requester currently being served
   logic [1:0]         gnt;
   logic               rsp_take;

   rr_arbiter2 u_rr (
      .req        ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .gnt        (gnt)
   );

   assign rsp_take = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
   assign busy     = (state != IDLE);

   // Next-state and the accept strobes; ready only in IDLE and never while reset is held.
   always_comb begin
      state_nx   = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (|gnt) begin
               state_nx   = WAIT;
               req0_ready = gnt[0] & reset_n;
               req1_ready = gnt[1] & reset_n;
            end
         end
         WAIT:    if (cnt == CBITS'(ALU_LAT - 1)) state_nx = CAPT;
         CAPT:    state_nx = RESP;
         RESP:    if (rsp_take) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, counter, grant history, ALU operand registers and response registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         who        <= 1'b0;
         alu_opsel  <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
      end else begin
         // NOTE: non-blocking so every register here samples pre-edge values.
         state <= state_nx;
         case (state)
            IDLE: begin
               if (|gnt) begin
                  who        <= gnt[1];
                  last_grant <= gnt[1];
                  cnt        <= '0;
                  alu_opsel  <= gnt[1] ? req1_op : req0_op;
                  alu_a      <= gnt[1] ? req1_a  : req0_a;
                  alu_b      <= gnt[1] ? req1_b  : req0_b;
               end
            end
            WAIT: cnt <= cnt + 1'b1;
            CAPT: begin
               if (who) begin
                  rsp1_data  <= alu_out;
                  rsp1_valid <= 1'b1;
               end else begin
                  rsp0_data  <= alu_out;
                  rsp0_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp0_valid && rsp0_ready) rsp0_valid <= 1'b0;
               if (rsp1_valid && rsp1_ready) rsp1_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter with a one-cycle registered ALU attached.
`timescale 1ns/1ps
module tb_alu_arbiter;
   import alu_ctrl_pkg::*;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [5:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_data, rsp1_data;
   logic [5:0]  alu_opsel;
   logic [31:0] alu_a, alu_b;
   logic [31:0] alu_out = '0;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #100 clk = ~clk;

   alu_arbiter #(.DBITS(32), .OPBITS(6), .ALU_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .alu_opsel(alu_opsel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
      .busy(busy)
   );

   function automatic logic [31:0] alu_ref(logic [5:0] op, logic [31:0] a, logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NAND: return ~(a & b);
         OP_NOR:  return ~(a | b);
         OP_XNOR: return ~(a ^ b);
         OP_MVHI: return {b[15:0], 16'h0000};
         default: return a;
      endcase
   endfunction

   // The ALU owned by the parent: one registered stage.
   always @(posedge clk) alu_out <= alu_ref(alu_opsel, alu_a, alu_b);

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   // ---------------- transaction-level reference model ----------------
   // One op at a time; its result is due LAT+2 sampled cycles after the accept cycle
   // and stays up until the owner takes it.
   int          cyc = 0;
   bit          m_idle = 1'b1, m_last = 1'b1, m_who = 1'b0;
   int          m_acc = 0;
   logic [5:0]  m_op = '0;
   logic [31:0] m_a = '0, m_b = '0, m_res = '0;
   int          n_srv0 = 0, n_srv1 = 0;
   bit          e0, e1, rv;

   always @(negedge clk) begin
      if (!reset_n) begin
         m_idle = 1'b1; m_last = 1'b1; m_op = '0; m_a = '0; m_b = '0;
      end else begin
         cyc++;
         check("alu_opsel", alu_opsel, m_op);
         check("alu_a", alu_a, m_a);
         check("alu_b", alu_b, m_b);
         check("busy", busy, !m_idle);
         if (m_idle) begin
            e0 = req0_valid && (!req1_valid || m_last);
            e1 = req1_valid && !e0;
            check("req0_ready", req0_ready, e0);
            check("req1_ready", req1_ready, e1);
            check("rsp0_valid_idle", rsp0_valid, 0);
            check("rsp1_valid_idle", rsp1_valid, 0);
            if (e0 || e1) begin
               m_who = e1; m_last = e1; m_acc = cyc; m_idle = 1'b0;
               m_op  = e1 ? req1_op : req0_op;
               m_a   = e1 ? req1_a  : req0_a;
               m_b   = e1 ? req1_b  : req0_b;
               m_res = alu_ref(m_op, m_a, m_b);
            end
         end else begin
            rv = (cyc >= m_acc + LAT + 2);
            check("req0_ready_busy", req0_ready, 0);
            check("req1_ready_busy", req1_ready, 0);
            check("rsp0_valid", rsp0_valid, rv && !m_who);
            check("rsp1_valid", rsp1_valid, rv && m_who);
            if (rv) begin
               check("rsp_data", m_who ? rsp1_data : rsp0_data, m_res);
               if (m_who ? rsp1_ready : rsp0_ready) begin
                  m_idle = 1'b1;
                  if (m_who) n_srv1++; else n_srv0++;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_req(bit n, bit v, logic [5:0] op, logic [31:0] a, logic [31:0] b);
      if (n) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
      else   begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
   endtask

   task automatic check_zero(string tag);
      check({tag, "_req0_ready"}, req0_ready, 0);
      check({tag, "_req1_ready"}, req1_ready, 0);
      check({tag, "_rsp0_valid"}, rsp0_valid, 0);
      check({tag, "_rsp1_valid"}, rsp1_valid, 0);
      check({tag, "_rsp0_data"}, rsp0_data, 0);
      check({tag, "_rsp1_data"}, rsp1_data, 0);
      check({tag, "_alu_opsel"}, alu_opsel, 0);
      check({tag, "_alu_a"}, alu_a, 0);
      check({tag, "_alu_b"}, alu_b, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_reset(string tag);
      reset_n = 1'b0;
      #1 check_zero(tag);
      tick();
      reset_n = 1'b1;
   endtask

   // Wait for requester n to be accepted, then withdraw its request.
   task automatic wait_acc(bit n, string tag, int max);
      bit found = 1'b0;
      for (int i = 0; i < max && !found; i++) begin
         @(negedge clk);
         found = n ? req1_ready : req0_ready;
      end
      check({tag, "_accepted"}, found, 1);
      tick();
      if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   // Wait for a response on channel n and compare it with a fixed value.
   task automatic wait_rsp(bit n, logic [31:0] exp, string tag, int max);
      bit found = 1'b0;
      for (int i = 0; i < max && !found; i++) begin
         @(negedge clk);
         found = n ? rsp1_valid : rsp0_valid;
      end
      check({tag, "_seen"}, found, 1);
      if (found) check(tag, n ? rsp1_data : rsp0_data, exp);
      tick();
   endtask

   // Present two ops in the same cycle and record the order in which results come back.
   task automatic run_pair(string tag, logic [5:0] op0, logic [5:0] op1,
                           bit first, logic [31:0] d_first, logic [31:0] d_second);
      bit          a0, a1;
      int          got = 0;
      bit          who_q [2];
      logic [31:0] dat_q [2];
      set_req(0, 1, op0, 20, 17);
      set_req(1, 1, op1, 20, 17);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 24 && got < 2; i++) begin
         @(negedge clk);
         a0 = req0_valid & req0_ready;
         a1 = req1_valid & req1_ready;
         if (rsp0_valid && got < 2) begin who_q[got] = 0; dat_q[got] = rsp0_data; got++; end
         if (rsp1_valid && got < 2) begin who_q[got] = 1; dat_q[got] = rsp1_data; got++; end
         tick();
         if (a0) req0_valid = 1'b0;
         if (a1) req1_valid = 1'b0;
      end
      check({tag, "_count"}, got, 2);
      if (got == 2) begin
         check({tag, "_first_who"}, who_q[0], first);
         check({tag, "_first_data"}, dat_q[0], d_first);
         check({tag, "_second_who"}, who_q[1], !first);
         check({tag, "_second_data"}, dat_q[1], d_second);
      end
   endtask

   initial begin
      #(200 * 20000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a0, a1;
      int s0, s1;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      reset_n = 1'b0;
      #1 check_zero("rst");
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // 1: single ADD on requester 0
      set_req(0, 1, OP_ADD, 20, 17);
      rsp0_ready = 1'b1;
      wait_acc(0, "t1", 4);
      wait_rsp(0, 32'd37, "t1_rsp0", 8);
      repeat (3) tick();

      // 2: simultaneous pair after reset -> req0 first; after a lone req0 op, req1 first
      do_reset("t2_rst");
      tick();
      run_pair("t2a", OP_SUB, OP_OR, 0, 32'd3, 32'd21);
      set_req(0, 1, OP_ADD, 20, 17);
      wait_acc(0, "t2_solo", 4);
      wait_rsp(0, 32'd37, "t2_solo_rsp", 8);
      run_pair("t2b", OP_SUB, OP_OR, 1, 32'd21, 32'd3);
      tick();

      // 3: requester 1 stalls its response; requester 0 waits
      rsp1_ready = 1'b0; rsp0_ready = 1'b1;
      set_req(1, 1, OP_NAND, 20, 17);
      set_req(0, 1, OP_ADD, 20, 17);
      wait_acc(1, "t3", 4);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("t3_rsp1_valid", rsp1_valid, 1);
         check("t3_rsp1_data", rsp1_data, 32'hFFFF_FFEF);
         check("t3_busy", busy, 1);
         check("t3_req0_ready", req0_ready, 0);
      end
      tick();
      rsp1_ready = 1'b1;
      wait_acc(0, "t3_req0", 6);
      wait_rsp(0, 32'd37, "t3_rsp0", 8);
      tick();

      // 4: reset while the ALU is working; the op vanishes
      set_req(0, 1, OP_ADD, 20, 17);
      wait_acc(0, "t4", 4);
      do_reset("t4_rst");
      repeat (5) tick();
      set_req(0, 1, OP_XOR, 20, 17);
      wait_acc(0, "t4_xor", 4);
      wait_rsp(0, 32'd5, "t4_rsp0", 8);
      repeat (2) tick();

      // 5: held requests, one op every LAT+3 cycles, fair interleave
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      s0 = n_srv0;
      set_req(0, 1, OP_XNOR, 20, 17);
      repeat (16) @(negedge clk);
      #1 check("t5_rate0", n_srv0 - s0, 4);
      tick();
      s0 = n_srv0; s1 = n_srv1;
      set_req(1, 1, OP_XNOR, 20, 17);
      repeat (16) @(negedge clk);
      #1;
      check("t5_fair0", n_srv0 - s0, 2);
      check("t5_fair1", n_srv1 - s1, 2);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (6) tick();

      // random traffic against the model
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         a0 = req0_valid & req0_ready;
         a1 = req1_valid & req1_ready;
         tick();
         if (a0 || !req0_valid)
            set_req(0, $urandom_range(1, 0) == 1, 6'($urandom_range(15, 0)), $urandom, $urandom);
         else if ($urandom_range(15, 0) == 0)
            req0_valid = 1'b0;
         if (a1 || !req1_valid)
            set_req(1, $urandom_range(1, 0) == 1, 6'($urandom_range(15, 0)), $urandom, $urandom);
         else if ($urandom_range(15, 0) == 0)
            req1_valid = 1'b0;
         rsp0_ready = $urandom_range(1, 0) == 1;
         rsp1_ready = $urandom_range(1, 0) == 1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
